// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 CPU bus controller and its address decoder.
// Region codes are reused by any path that needs to classify a 6502 address.
package c64_bus_pkg;

  typedef enum logic [2:0] {
    REG_VEC,
    REG_ROM,
    REG_IO,
    REG_RAM,
    REG_EXT
  } region_t;

  // External-access FSM encoding, kept as plain constants for legacy tools
  typedef logic [1:0] ext_state_t;
  localparam ext_state_t ST_IDLE = 2'd0;
  localparam ext_state_t ST_REQ  = 2'd1;
  localparam ext_state_t ST_WAIT = 2'd2;
  localparam ext_state_t ST_DONE = 2'd3;

  localparam logic [5:0] BORDER_IDX = 6'h20;
  localparam logic [5:0] BG0_IDX    = 6'h21;

  localparam logic [15:0] NMI_VEC_ADDR   = 16'hFFFA;
  localparam logic [15:0] RESET_VEC_ADDR = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_ADDR   = 16'hFFFE;

  // Byte of the vector table at offset 'off' from $FFFA, little-endian
  function automatic logic [7:0] vec_byte(input logic [2:0]  off,
                                          input logic [15:0] nmi_v,
                                          input logic [15:0] rst_v,
                                          input logic [15:0] irq_v);
    logic [15:0] a;
    logic [15:0] v;
    a = NMI_VEC_ADDR + {13'd0, off};
    if (a[15:1] == RESET_VEC_ADDR[15:1]) v = rst_v;
    else if (a[15:1] == IRQ_VEC_ADDR[15:1]) v = irq_v;
    else v = nmi_v;
    return a[0] ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/c64_addr_decode.sv
// Combinational 6502 address decoder: region plus local offset for each target.
// Priority is vectors, ROM, IO, RAM, then everything else is external.
module c64_addr_decode
  import c64_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = 16'hC000,
  parameter int          ROM_AW   = 6,
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] IO_BASE  = 16'hD000,
  parameter int          IO_AW    = 6
) (
  input  logic [15:0]       addr,
  output region_t           region,
  output logic [2:0]        vec_off,
  output logic [ROM_AW-1:0] rom_off,
  output logic [IO_AW-1:0]  io_off,
  output logic [RAM_AW-1:0] ram_off
);

  // Bounds are widened to 17 bits so a window ending at $FFFF cannot wrap
  localparam logic [16:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [16:0] ROM_HI = ROM_LO + 17'(2**ROM_AW);
  localparam logic [16:0] IO_LO  = {1'b0, IO_BASE};
  localparam logic [16:0] IO_HI  = IO_LO + 17'(2**IO_AW);
  localparam logic [16:0] RAM_HI = 17'(2**RAM_AW);

  logic [16:0] addr_x;
  logic        vec_hit;
  logic        rom_hit;
  logic        io_hit;
  logic        ram_hit;

  assign addr_x = {1'b0, addr};

  always_comb begin
    vec_hit = (addr >= NMI_VEC_ADDR);
    rom_hit = (addr_x >= ROM_LO) && (addr_x < ROM_HI);
    io_hit  = (addr_x >= IO_LO) && (addr_x < IO_HI);
    ram_hit = (addr_x < RAM_HI);
    if (vec_hit)      region = REG_VEC;
    else if (rom_hit) region = REG_ROM;
    else if (io_hit)  region = REG_IO;
    else if (ram_hit) region = REG_RAM;
    else              region = REG_EXT;
  end

  assign vec_off = addr[2:0] - NMI_VEC_ADDR[2:0];
  assign rom_off = addr[ROM_AW-1:0] - ROM_BASE[ROM_AW-1:0];
  assign io_off  = addr[IO_AW-1:0] - IO_BASE[IO_AW-1:0];
  assign ram_off = addr[RAM_AW-1:0];

endmodule

// File: rtl/c64_bus_ctrl.sv
// 6502 bus controller: vectors, loadable boot ROM, scratch RAM, IO registers and a stalling
// handshake to memCtrl. There is no ext timeout: a missing ext_done stalls the core forever.
module c64_bus_ctrl
  import c64_bus_pkg::*;
#(
  parameter logic [15:0] ROM_BASE  = 16'hC000,
  parameter int          ROM_AW    = 6,
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] IO_BASE   = 16'hD000,
  parameter int          IO_AW     = 6,
  parameter logic [15:0] RESET_VEC = 16'hC000,
  parameter logic [15:0] NMI_VEC   = 16'hC000,
  parameter logic [15:0] IRQ_VEC   = 16'hC000,
  parameter bit          EXT_EN    = 1'b1
) (
  input  logic              clkPhi0,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic              we,
  input  logic [7:0]        dataFromCpu,
  output logic [7:0]        dataToCpu,
  output logic              rdy,
  input  logic              romLoadEn,
  input  logic [ROM_AW-1:0] romLoadAddr,
  input  logic [7:0]        romLoadData,
  output logic              ioWrStb,
  output logic [IO_AW-1:0]  ioIndex,
  output logic [7:0]        ioData,
  output logic [3:0]        borderColour,
  output logic              ext_req,
  output logic              ext_write,
  output logic [15:0]       ext_addr,
  output logic [7:0]        ext_wdata,
  input  logic [7:0]        ext_rdata,
  input  logic              ext_done
);

  localparam int ROM_SIZE = 2**ROM_AW;
  localparam int RAM_SIZE = 2**RAM_AW;
  localparam int IO_SIZE  = 2**IO_AW;

  region_t           region;
  logic [2:0]        vec_off;
  logic [ROM_AW-1:0] rom_off;
  logic [IO_AW-1:0]  io_off;
  logic [RAM_AW-1:0] ram_off;

  c64_addr_decode #(
    .ROM_BASE(ROM_BASE),
    .ROM_AW  (ROM_AW),
    .RAM_AW  (RAM_AW),
    .IO_BASE (IO_BASE),
    .IO_AW   (IO_AW)
  ) u_decode (
    .addr   (addr),
    .region (region),
    .vec_off(vec_off),
    .rom_off(rom_off),
    .io_off (io_off),
    .ram_off(ram_off)
  );

  logic [7:0] rom_mem   [ROM_SIZE];
  logic [7:0] ram_mem   [RAM_SIZE];
  logic [7:0] io_regs_q [IO_SIZE];
  logic [7:0] io_regs_d [IO_SIZE];

  ext_state_t       state_q, state_d;
  logic [7:0]       data_to_cpu_q, data_to_cpu_d;
  logic             io_wr_stb_q, io_wr_stb_d;
  logic [IO_AW-1:0] io_index_q, io_index_d;
  logic [7:0]       io_data_q, io_data_d;
  logic             ext_req_q, ext_req_d;
  logic             ext_write_q, ext_write_d;
  logic [15:0]      ext_addr_q, ext_addr_d;
  logic [7:0]       ext_wdata_q, ext_wdata_d;

  logic ext_hit;
  logic served;
  logic io_wr;
  logic ram_wr;

  assign ext_hit = EXT_EN && (region == REG_EXT);
  assign served  = (state_q == ST_DONE);
  assign io_wr   = we && (region == REG_IO);
  assign ram_wr  = we && (region == REG_RAM);
  assign rdy     = !(ext_hit && !served);

  // Loader and CPU writes use the pre-edge contents, so same-cycle reads see the old byte
  always_ff @(posedge clkPhi0) begin
    if (romLoadEn) rom_mem[romLoadAddr] <= romLoadData;
  end

  always_ff @(posedge clkPhi0) begin
    if (ram_wr) ram_mem[ram_off] <= dataFromCpu;
  end

  always_comb begin
    io_regs_d = io_regs_q;
    if (io_wr) io_regs_d[io_off] = dataFromCpu;
  end

  always_comb begin
    io_wr_stb_d = io_wr;
    io_index_d  = io_wr ? io_off : io_index_q;
    io_data_d   = io_wr ? dataFromCpu : io_data_q;
  end

  // Read data path; writes and stalled ext cycles hold the last value
  always_comb begin
    data_to_cpu_d = data_to_cpu_q;
    if (!we) begin
      case (region)
        REG_VEC: data_to_cpu_d = vec_byte(vec_off, NMI_VEC, RESET_VEC, IRQ_VEC);
        REG_ROM: data_to_cpu_d = rom_mem[rom_off];
        REG_IO:  data_to_cpu_d = io_regs_q[io_off];
        REG_RAM: data_to_cpu_d = ram_mem[ram_off];
        default: if (!EXT_EN) data_to_cpu_d = 8'hFF;
      endcase
    end
    if (EXT_EN && (state_q == ST_WAIT) && ext_done && !ext_write_q)
      data_to_cpu_d = ext_rdata;
  end

  always_comb begin
    state_d     = state_q;
    ext_req_d   = 1'b0;
    ext_write_d = ext_write_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ext_hit) begin
          ext_addr_d  = addr;
          ext_write_d = we;
          ext_wdata_d = dataFromCpu;
          ext_req_d   = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (ext_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkPhi0 or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      data_to_cpu_q <= 8'h00;
      io_wr_stb_q   <= 1'b0;
      io_index_q    <= '0;
      io_data_q     <= 8'h00;
      io_regs_q     <= '{default: 8'h00};
      ext_req_q     <= 1'b0;
      ext_write_q   <= 1'b0;
      ext_addr_q    <= 16'h0000;
      ext_wdata_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      data_to_cpu_q <= data_to_cpu_d;
      io_wr_stb_q   <= io_wr_stb_d;
      io_index_q    <= io_index_d;
      io_data_q     <= io_data_d;
      io_regs_q     <= io_regs_d;
      ext_req_q     <= ext_req_d;
      ext_write_q   <= ext_write_d;
      ext_addr_q    <= ext_addr_d;
      ext_wdata_q   <= ext_wdata_d;
    end
  end

  assign dataToCpu    = data_to_cpu_q;
  assign ioWrStb      = io_wr_stb_q;
  assign ioIndex      = io_index_q;
  assign ioData       = io_data_q;
  assign borderColour = io_regs_q[BORDER_IDX[IO_AW-1:0]][3:0];
  assign ext_req      = ext_req_q;
  assign ext_write    = ext_write_q;
  assign ext_addr     = ext_addr_q;
  assign ext_wdata    = ext_wdata_q;

endmodule

// File: tb/tb_c64_bus_ctrl.sv
// Self-checking bench for c64_bus_ctrl: an EXT_EN=1 instance driven as a 6502 bus with a
// memCtrl model, plus an EXT_EN=0 instance; expected read data flows through a scoreboard queue.
module tb_c64_bus_ctrl;

  logic        clkPhi0 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = 16'hFFFC;
  logic        we = 1'b0;
  logic [7:0]  dataFromCpu = 8'h00;
  logic        romLoadEn = 1'b0;
  logic [5:0]  romLoadAddr = 6'd0;
  logic [7:0]  romLoadData = 8'h00;
  logic [7:0]  ext_rdata = 8'h00;
  logic        ext_done = 1'b0;

  logic [7:0]  dataToCpu;
  logic        rdy;
  logic        ioWrStb;
  logic [5:0]  ioIndex;
  logic [7:0]  ioData;
  logic [3:0]  borderColour;
  logic        ext_req;
  logic        ext_write;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;

  logic [15:0] addr_n = 16'hFFFC;
  logic        we_n = 1'b0;
  logic [7:0]  dout_n = 8'h00;
  logic [7:0]  data_n;
  logic        rdy_n;
  logic        io_stb_n;
  logic [5:0]  io_idx_n;
  logic [7:0]  io_data_n;
  logic [3:0]  border_n;
  logic        ext_req_n;
  logic        ext_write_n;
  logic [15:0] ext_addr_n;
  logic [7:0]  ext_wdata_n;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] rom_model [64];
  logic [7:0] ram_model [1024];
  logic [7:0] io_model  [64];

  c64_bus_ctrl #(.EXT_EN(1'b1)) u_dut (
    .clkPhi0(clkPhi0), .reset(reset), .addr(addr), .we(we), .dataFromCpu(dataFromCpu),
    .dataToCpu(dataToCpu), .rdy(rdy), .romLoadEn(romLoadEn), .romLoadAddr(romLoadAddr),
    .romLoadData(romLoadData), .ioWrStb(ioWrStb), .ioIndex(ioIndex), .ioData(ioData),
    .borderColour(borderColour), .ext_req(ext_req), .ext_write(ext_write),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_done(ext_done)
  );

  c64_bus_ctrl #(.EXT_EN(1'b0)) u_dut_noext (
    .clkPhi0(clkPhi0), .reset(reset), .addr(addr_n), .we(we_n), .dataFromCpu(dout_n),
    .dataToCpu(data_n), .rdy(rdy_n), .romLoadEn(romLoadEn), .romLoadAddr(romLoadAddr),
    .romLoadData(romLoadData), .ioWrStb(io_stb_n), .ioIndex(io_idx_n), .ioData(io_data_n),
    .borderColour(border_n), .ext_req(ext_req_n), .ext_write(ext_write_n),
    .ext_addr(ext_addr_n), .ext_wdata(ext_wdata_n), .ext_rdata(ext_rdata), .ext_done(ext_done)
  );

  always #5 clkPhi0 = ~clkPhi0;

  function automatic bit is_io(input logic [15:0] a);
    return (a >= 16'hD000) && (a < 16'hD040);
  endfunction

  // Reference memory map built from the address plan, not from the design
  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [15:0] v;
    if (a >= 16'hFFFA) begin
      v = 16'hC000;
      return a[0] ? v[15:8] : v[7:0];
    end
    if (a >= 16'hC000 && a < 16'hC040) return rom_model[a[5:0]];
    if (is_io(a)) return io_model[a[5:0]];
    if (a < 16'h0400) return ram_model[a[9:0]];
    return 8'hFF;
  endfunction

  task automatic step();
    @(posedge clkPhi0);
    #1;
  endtask

  // One mapped bus cycle on the main instance; the expected dataToCpu goes to the scoreboard
  task automatic drive_cycle(input logic [15:0] a, input bit w, input logic [7:0] d);
    logic [7:0] exp;
    addr = a;
    we = w;
    dataFromCpu = d;
    exp = w ? last_exp : model_read(a);
    if (w && is_io(a)) io_model[a[5:0]] = d;
    if (w && a < 16'h0400) ram_model[a[9:0]] = d;
    last_exp = exp;
    sb.push_back(exp);
    step();
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset = 1'b0;
    addr = 16'hFFFC;
    repeat (3) step();
    for (int i = 0; i < 64; i++) io_model[i] = 8'h00;
    last_exp = 8'h00;
    sb.push_back(8'h00);
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL reset_data: got %h want %h", dataToCpu, exp); end
    checks++; if (ioWrStb !== 1'b0) begin errors++; $display("[TB] FAIL reset_iostb: got %b want 0", ioWrStb); end
    checks++; if (ioIndex !== 6'h00) begin errors++; $display("[TB] FAIL reset_ioindex: got %h want 00", ioIndex); end
    checks++; if (ioData !== 8'h00) begin errors++; $display("[TB] FAIL reset_iodata: got %h want 00", ioData); end
    checks++; if (borderColour !== 4'h0) begin errors++; $display("[TB] FAIL reset_border: got %h want 0", borderColour); end
    checks++; if ({ext_req, ext_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ext_ctl: got %b want 00", {ext_req, ext_write}); end
    checks++; if ({ext_addr, ext_wdata} !== 24'h0) begin errors++; $display("[TB] FAIL reset_ext_bus: got %h want 000000", {ext_addr, ext_wdata}); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy: got %b want 1", rdy); end
    checks++; if (data_n !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_noext: got %h want 00", data_n); end
  endtask

  task automatic test_reset_fetch();
    logic [15:0] vaddr [6] = '{16'hFFFC, 16'hFFFD, 16'hFFFA, 16'hFFFB, 16'hFFFE, 16'hFFFF};
    logic [7:0] exp;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(vaddr[i], 1'b0, 8'h00);
      exp = sb.pop_front();
      checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL vector_%h: got %h want %h", vaddr[i], dataToCpu, exp); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL vector_rdy_%h: got %b want 1", vaddr[i], rdy); end
    end
  endtask

  task automatic test_rom_load();
    logic [7:0] img [6] = '{8'h8D, 8'h20, 8'hD0, 8'h4C, 8'h00, 8'hC0};
    logic [7:0] exp;
    for (int i = 0; i < 7; i++) begin
      romLoadEn = 1'b1;
      romLoadAddr = (i < 6) ? 6'(i) : 6'd63;
      romLoadData = (i < 6) ? img[i] : 8'h5A;
      drive_cycle(16'hFFFD, 1'b0, 8'h00);
      rom_model[romLoadAddr] = romLoadData;
      void'(sb.pop_front());
    end
    // Loader overwrite racing a CPU read of the same byte
    romLoadAddr = 6'd63;
    romLoadData = 8'h6B;
    drive_cycle(16'hC03F, 1'b0, 8'h00);
    rom_model[63] = 8'h6B;
    romLoadEn = 1'b0;
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL rom_same_cycle_old: got %h want %h", dataToCpu, exp); end
    drive_cycle(16'hC03F, 1'b0, 8'h00);
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL rom_after_load: got %h want %h", dataToCpu, exp); end
  endtask

  task automatic test_boot_loop();
    logic [15:0] ta [8] = '{16'hC000, 16'hC001, 16'hC002, 16'hD020, 16'hC003, 16'hC004, 16'hC005, 16'hC000};
    bit          tw [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(ta[i], tw[i], 8'h05);
      exp = sb.pop_front();
      checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL boot_data_%0d: got %h want %h", i, dataToCpu, exp); end
      checks++; if (ioWrStb !== tw[i]) begin errors++; $display("[TB] FAIL boot_iostb_%0d: got %b want %b", i, ioWrStb, tw[i]); end
      if (tw[i]) begin
        checks++; if (ioIndex !== 6'h20) begin errors++; $display("[TB] FAIL boot_ioindex: got %h want 20", ioIndex); end
        checks++; if (ioData !== 8'h05) begin errors++; $display("[TB] FAIL boot_iodata: got %h want 05", ioData); end
        checks++; if (borderColour !== 4'h5) begin errors++; $display("[TB] FAIL boot_border: got %h want 5", borderColour); end
      end
    end
  endtask

  task automatic test_ram();
    logic [15:0] ta [8] = '{16'h0123, 16'h0123, 16'hC002, 16'hC002, 16'h03FF, 16'h03FF, 16'h0000, 16'h0000};
    bit          tw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  td [8] = '{8'hA5, 8'h00, 8'h55, 8'h00, 8'h3C, 8'h00, 8'h11, 8'h00};
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(ta[i], tw[i], td[i]);
      exp = sb.pop_front();
      checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL ram_%0d_%h: got %h want %h", i, ta[i], dataToCpu, exp); end
    end
  endtask

  task automatic test_io();
    logic [15:0] ta [5] = '{16'hD021, 16'hD021, 16'hD03F, 16'hD03F, 16'hD020};
    bit          tw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  td [5] = '{8'h3B, 8'h00, 8'h81, 8'h00, 8'h00};
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(ta[i], tw[i], td[i]);
      exp = sb.pop_front();
      checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL io_%0d_%h: got %h want %h", i, ta[i], dataToCpu, exp); end
      checks++; if (ioWrStb !== tw[i]) begin errors++; $display("[TB] FAIL io_stb_%0d: got %b want %b", i, ioWrStb, tw[i]); end
    end
    checks++; if ({ioIndex, ioData} !== {6'h3F, 8'h81}) begin errors++; $display("[TB] FAIL io_last_write: got %h/%h want 3f/81", ioIndex, ioData); end
    checks++; if (borderColour !== 4'h5) begin errors++; $display("[TB] FAIL io_border_kept: got %h want 5", borderColour); end
  endtask

  // Ext read with a memCtrl model answering 'delay' cycles after the request pulse
  task automatic test_ext_read(input logic [15:0] a, input logic [7:0] d, input int delay);
    int low_cnt = 0;
    int req_cnt = 0;
    int req_cyc = -1;
    bit finished = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic req_wr = 1'b1;
    logic [7:0] exp;
    addr = a;
    we = 1'b0;
    ext_rdata = d;
    sb.push_back(d);
    last_exp = d;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      ext_done = 1'b0;
      if (ext_req) begin
        req_cnt++;
        if (req_cyc < 0) begin req_cyc = cyc; req_addr = ext_addr; req_wr = ext_write; end
      end
      if (rdy) begin finished = 1'b1; break; end
      low_cnt++;
      ext_done = (req_cyc >= 0) && (cyc == req_cyc + delay);
      step();
    end
    ext_done = 1'b0;
    checks++; if (!finished) begin errors++; $display("[TB] FAIL ext_read_timeout_%h: rdy never returned", a); end
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL ext_read_data_%h: got %h want %h", a, dataToCpu, exp); end
    checks++; if (low_cnt != delay + 2) begin errors++; $display("[TB] FAIL ext_read_stall_%h: got %0d want %0d", a, low_cnt, delay + 2); end
    checks++; if (req_cnt != 1) begin errors++; $display("[TB] FAIL ext_read_req_pulses_%h: got %0d want 1", a, req_cnt); end
    checks++; if (req_addr !== a) begin errors++; $display("[TB] FAIL ext_read_addr: got %h want %h", req_addr, a); end
    checks++; if (req_wr !== 1'b0) begin errors++; $display("[TB] FAIL ext_read_write_flag: got %b want 0", req_wr); end
    drive_cycle(16'h0123, 1'b0, 8'h00);
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL ext_read_next_%h: got %h want %h", a, dataToCpu, exp); end
    checks++; if ({ext_req, rdy} !== 2'b01) begin errors++; $display("[TB] FAIL ext_read_idle_%h: req/rdy got %b want 01", a, {ext_req, rdy}); end
  endtask

  task automatic test_ext_write_reset();
    logic [7:0] exp;
    addr = 16'h4000;
    we = 1'b1;
    dataFromCpu = 8'h77;
    step();
    checks++; if ({ext_req, ext_write, rdy} !== 3'b110) begin errors++; $display("[TB] FAIL extwr_req: req/wr/rdy got %b want 110", {ext_req, ext_write, rdy}); end
    checks++; if ({ext_addr, ext_wdata} !== {16'h4000, 8'h77}) begin errors++; $display("[TB] FAIL extwr_bus: got %h/%h want 4000/77", ext_addr, ext_wdata); end
    step();
    checks++; if (ext_req !== 1'b0) begin errors++; $display("[TB] FAIL extwr_single_pulse: got %b want 0", ext_req); end
    // Reset lands while the FSM waits for memCtrl
    reset = 1'b0;
    addr = 16'hFFFC;
    we = 1'b0;
    #1;
    checks++; if ({ext_req, rdy} !== 2'b01) begin errors++; $display("[TB] FAIL extwr_reset_req_rdy: got %b want 01", {ext_req, rdy}); end
    checks++; if (borderColour !== 4'h0) begin errors++; $display("[TB] FAIL extwr_reset_border: got %h want 0", borderColour); end
    checks++; if ({ext_write, ext_addr, ext_wdata} !== 25'h0) begin errors++; $display("[TB] FAIL extwr_reset_ext: got %b/%h/%h want 0", ext_write, ext_addr, ext_wdata); end
    reset = 1'b1;
    for (int i = 0; i < 64; i++) io_model[i] = 8'h00;
    last_exp = 8'h00;
    // Late completion must not reach the CPU or restart the FSM
    ext_rdata = 8'hEE;
    ext_done = 1'b1;
    drive_cycle(16'h0123, 1'b0, 8'h00);
    ext_done = 1'b0;
    exp = sb.pop_front();
    checks++; if (dataToCpu !== exp) begin errors++; $display("[TB] FAIL extwr_late_done_data: got %h want %h", dataToCpu, exp); end
    checks++; if ({ext_req, rdy} !== 2'b01) begin errors++; $display("[TB] FAIL extwr_late_done_idle: got %b want 01", {ext_req, rdy}); end
    test_ext_read(16'h9000, 8'h42, 3);
  endtask

  task automatic test_ext_disabled();
    logic [15:0] ta [8] = '{16'hFFFD, 16'h8000, 16'h8000, 16'hC03F, 16'hC040, 16'hD040, 16'h0400, 16'hD03F};
    bit          tw [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0]  te [8] = '{8'hC0, 8'hC0, 8'hFF, 8'h6B, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      addr_n = ta[i];
      we_n = tw[i];
      dout_n = 8'h99;
      sb.push_back(te[i]);
      #1;
      checks++; if (rdy_n !== 1'b1) begin errors++; $display("[TB] FAIL noext_rdy_%0d: got %b want 1", i, rdy_n); end
      step();
      exp = sb.pop_front();
      checks++; if (data_n !== exp) begin errors++; $display("[TB] FAIL noext_data_%0d_%h: got %h want %h", i, ta[i], data_n, exp); end
      checks++; if (ext_req_n !== 1'b0) begin errors++; $display("[TB] FAIL noext_req_%0d: got %b want 0", i, ext_req_n); end
    end
    we_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_rom_load();
    test_boot_loop();
    test_ram();
    test_io();
    test_ext_read(16'h8000, 8'h3C, 5);
    test_ext_write_reset();
    test_ext_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
